// File: rtl/mips_processor.sv
// mips_processor: single-cycle MIPS-I subset CPU, one instruction retired per rising clk edge
// Ports: clk    - sole clock, all state updates on the rising edge
//        rst_n  - asynchronous active-low reset; clears pc and the register file (memories keep contents)
//        pc     - address of the instruction currently executing
module mips_storage #(
  parameter int BYTES = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(BYTES);
  logic [7:0] bytes [0:BYTES-1];
  logic [AW-1:0] idx [4];
  always_comb
    for (int k = 0; k < 4; k++) idx[k] = AW'((addr + 32'(k)) % 32'(BYTES));
  assign rdata = {bytes[idx[0]], bytes[idx[1]], bytes[idx[2]], bytes[idx[3]]};
  always_ff @(posedge clk)
    if (we)
      for (int k = 0; k < 4; k++) bytes[idx[k]] <= wdata[31-8*k -: 8];
endmodule

module mips_imemory #(
  parameter int BYTES = 1024
) (
  input  logic        clk,
  input  logic [31:0] addr,
  output logic [31:0] rdata
);
  mips_storage #(.BYTES(BYTES)) storage (
    .clk(clk), .we(1'b0), .addr(addr), .wdata(32'd0), .rdata(rdata)
  );
endmodule

module mips_ifu #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  mips_imemory #(.BYTES(IMEM_BYTES)) imemory (.clk(clk), .addr(pc), .rdata(instr));
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] registers [0:31];
  assign rd1 = ra1 == 5'd0 ? 32'd0 : registers[ra1];
  assign rd2 = ra2 == 5'd0 ? 32'd0 : registers[ra2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
    else if (we && wa != 5'd0)
      registers[wa] <= wd;
endmodule

module mips_processor #(
  parameter int IMEM_BYTES = 1024,
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc
);
  logic [31:0] pc_q, pc_d, instr, rs_v, rt_v, wd, mem_rd, pc4, simm, zimm, br_tgt, jmp_tgt, mem_a;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh, wa;
  logic        we, mem_we, rs_neg;
  assign {op, rs, rt, rd, sh, fn} = instr;
  assign simm = {{16{instr[15]}}, instr[15:0]};
  assign zimm = {16'd0, instr[15:0]};
  assign pc4 = pc_q + 32'd4;
  assign br_tgt = pc4 + {simm[29:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], instr[25:0], 2'b00};
  assign mem_a = rs_v + simm;
  assign rs_neg = rs_v[31];
  assign pc = pc_q;
  mips_ifu #(.IMEM_BYTES(IMEM_BYTES)) IFU (.clk(clk), .pc(pc_q), .instr(instr));
  mips_regfile registers (
    .clk(clk), .rst_n(rst_n), .ra1(rs), .ra2(rt), .we(we), .wa(wa), .wd(wd), .rd1(rs_v), .rd2(rt_v)
  );
  mips_storage #(.BYTES(DMEM_BYTES)) dmem (
    .clk(clk), .we(mem_we), .addr(mem_a), .wdata(rt_v), .rdata(mem_rd)
  );
  always_comb begin
    pc_d = pc4;
    we = 1'b0;
    wa = rt;
    wd = 32'd0;
    mem_we = 1'b0;
    case (op)
      6'h00: begin
        we = 1'b1;
        wa = rd;
        case (fn)
          6'h20, 6'h21: wd = rs_v + rt_v;
          6'h22, 6'h23: wd = rs_v - rt_v;
          6'h24: wd = rs_v & rt_v;
          6'h25: wd = rs_v | rt_v;
          6'h26: wd = rs_v ^ rt_v;
          6'h27: wd = ~(rs_v | rt_v);
          6'h2a: wd = {31'd0, $signed(rs_v) < $signed(rt_v)};
          6'h2b: wd = {31'd0, rs_v < rt_v};
          6'h00: wd = rt_v << sh;
          6'h02: wd = rt_v >> sh;
          6'h03: wd = $signed(rt_v) >>> sh;
          6'h08: begin
            we = 1'b0;
            pc_d = rs_v;
          end
          6'h09: begin
            wd = pc4;
            pc_d = rs_v;
          end
          default: we = 1'b0;
        endcase
      end
      // REGIMM: rt 0/1/16/17 only; rt[0] selects >=0, rt[4] links $ra regardless of outcome
      6'h01: if (rt[3:1] == 3'd0) begin
        we = rt[4];
        wa = 5'd31;
        wd = pc4;
        pc_d = rs_neg != rt[0] ? br_tgt : pc4;
      end
      6'h02: pc_d = jmp_tgt;
      6'h03: begin
        pc_d = jmp_tgt;
        we = 1'b1;
        wa = 5'd31;
        wd = pc4;
      end
      6'h04: pc_d = rs_v == rt_v ? br_tgt : pc4;
      6'h05: pc_d = rs_v != rt_v ? br_tgt : pc4;
      6'h06: pc_d = rs_neg || rs_v == 32'd0 ? br_tgt : pc4;
      6'h07: pc_d = !rs_neg && rs_v != 32'd0 ? br_tgt : pc4;
      6'h08, 6'h09: begin
        we = 1'b1;
        wd = rs_v + simm;
      end
      6'h0a: begin
        we = 1'b1;
        wd = {31'd0, $signed(rs_v) < $signed(simm)};
      end
      6'h0c: begin
        we = 1'b1;
        wd = rs_v & zimm;
      end
      6'h0d: begin
        we = 1'b1;
        wd = rs_v | zimm;
      end
      6'h0e: begin
        we = 1'b1;
        wd = rs_v ^ zimm;
      end
      6'h0f: begin
        we = 1'b1;
        wd = {instr[15:0], 16'd0};
      end
      6'h23: begin
        we = 1'b1;
        wd = mem_rd;
      end
      6'h2b: mem_we = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= 32'd0;
    else pc_q <= pc_d;
endmodule

// File: tb/tb_mips_processor.sv
// tb_mips_processor: directed trace table plus randomized programs checked against an ISA-level model
module tb_mips_processor;
  localparam int MB = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] pc;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  logic [7:0] m_imem [MB];
  logic [7:0] m_dmem [MB];
  typedef struct {
    int          addr;
    logic [31:0] ins;
    int          r;
    logic [31:0] v;
    logic [31:0] npc;
  } vec_t;
  vec_t tv [$];

  mips_processor #(.IMEM_BYTES(MB), .DMEM_BYTES(MB)) dut (.clk(clk), .rst_n(rst_n), .pc(pc));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  function automatic logic [1023:0] dut_regs();
    logic [1023:0] v;
    for (int r = 0; r < 32; r++) v[32*r +: 32] = dut.registers.registers[r];
    return v;
  endfunction

  function automatic logic [1023:0] model_regs();
    logic [1023:0] v;
    for (int r = 0; r < 32; r++) v[32*r +: 32] = m_reg[r];
    return v;
  endfunction

  task automatic put(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      m_imem[a+k] = w[31-8*k -: 8];
      dut.IFU.imemory.storage.bytes[10'(a+k)] = w[31-8*k -: 8];
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MB; i++) begin
      m_imem[i] = 8'd0;
      m_dmem[i] = 8'd0;
      dut.IFU.imemory.storage.bytes[10'(i)] = 8'd0;
      dut.dmem.bytes[10'(i)] = 8'd0;
    end
  endtask

  task automatic add(input int a, input logic [31:0] ins, input int r, input logic [31:0] v, input int npc);
    vec_t e;
    e.addr = a;
    e.ins = ins;
    e.r = r;
    e.v = v;
    e.npc = 32'(npc);
    tv.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Architectural reference: one instruction per call, straight from the ISA rules
  task automatic m_step();
    logic [31:0] ins, a, b, s, p4, np, wv, ad;
    int wr, op, fn, rs, rt, rd, sh, p, ai;
    p = int'(m_pc);
    ins = {m_imem[p], m_imem[p+1], m_imem[p+2], m_imem[p+3]};
    op = int'(ins[31:26]);
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rd = int'(ins[15:11]);
    sh = int'(ins[10:6]);
    fn = int'(ins[5:0]);
    a = m_reg[rs];
    b = m_reg[rt];
    s = {{16{ins[15]}}, ins[15:0]};
    p4 = m_pc + 32'd4;
    np = p4;
    wr = 0;
    wv = 32'd0;
    ad = a + s;
    ai = int'(ad[9:0]);
    case (op)
      0: case (fn)
        32, 33: begin wr = rd; wv = a + b; end
        34, 35: begin wr = rd; wv = a - b; end
        36: begin wr = rd; wv = a & b; end
        37: begin wr = rd; wv = a | b; end
        38: begin wr = rd; wv = a ^ b; end
        39: begin wr = rd; wv = ~(a | b); end
        42: begin wr = rd; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        43: begin wr = rd; wv = (a < b) ? 32'd1 : 32'd0; end
        0: begin wr = rd; wv = b << sh; end
        2: begin wr = rd; wv = b >> sh; end
        3: begin wr = rd; wv = $signed(b) >>> sh; end
        8: np = a;
        9: begin wr = rd; wv = p4; np = a; end
        default: ;
      endcase
      1: if (rt == 0 || rt == 1 || rt == 16 || rt == 17) begin
        if (rt >= 16) begin wr = 31; wv = p4; end
        if (($signed(a) < 0) == (rt == 0 || rt == 16)) np = p4 + (s << 2);
      end
      2: np = {p4[31:28], ins[25:0], 2'b00};
      3: begin np = {p4[31:28], ins[25:0], 2'b00}; wr = 31; wv = p4; end
      4: if (a == b) np = p4 + (s << 2);
      5: if (a != b) np = p4 + (s << 2);
      6: if ($signed(a) <= 0) np = p4 + (s << 2);
      7: if ($signed(a) > 0) np = p4 + (s << 2);
      8, 9: begin wr = rt; wv = a + s; end
      10: begin wr = rt; wv = ($signed(a) < $signed(s)) ? 32'd1 : 32'd0; end
      12: begin wr = rt; wv = a & {16'd0, ins[15:0]}; end
      13: begin wr = rt; wv = a | {16'd0, ins[15:0]}; end
      14: begin wr = rt; wv = a ^ {16'd0, ins[15:0]}; end
      15: begin wr = rt; wv = {ins[15:0], 16'd0}; end
      35: begin
        wr = rt;
        wv = {m_dmem[ai % MB], m_dmem[(ai+1) % MB], m_dmem[(ai+2) % MB], m_dmem[(ai+3) % MB]};
      end
      43: for (int k = 0; k < 4; k++) m_dmem[(ai+k) % MB] = b[31-8*k -: 8];
      default: ;
    endcase
    if (wr != 0) m_reg[wr] = wv;
    m_pc = np;
  endtask

  function automatic logic [31:0] rand_ins();
    int rs = int'($urandom_range(0, 31));
    int rt = int'($urandom_range(0, 31));
    int rd = int'($urandom_range(0, 31));
    int imm = int'($urandom_range(0, 65535));
    int off = int'($urandom_range(0, 12)) - 6;
    int rfn [10] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    int sfn [3] = '{0, 2, 3};
    int iop [7] = '{8, 9, 10, 12, 13, 14, 15};
    int rim [4] = '{0, 1, 16, 17};
    case ($urandom_range(0, 14))
      0, 1: return r_ins(rs, rt, rd, 0, rfn[$urandom_range(0, 9)]);
      2: return r_ins(rs, rt, rd, int'($urandom_range(0, 31)), sfn[$urandom_range(0, 2)]);
      3, 4, 5: return i_ins(iop[$urandom_range(0, 6)], rs, rt, imm);
      6: return i_ins(int'($urandom_range(4, 7)), rs, rt, off);
      7: return i_ins(1, rs, rim[$urandom_range(0, 3)], off);
      8: return j_ins(int'($urandom_range(2, 3)), int'($urandom_range(0, 200)));
      9: return i_ins(43, 0, rt, 4 * int'($urandom_range(0, 255)));
      10: return i_ins(35, 0, rt, 4 * int'($urandom_range(0, 255)));
      11: return $urandom_range(0, 1) ? i_ins(63, rs, rt, imm) : r_ins(rs, rt, rd, 0, 63);
      12: return r_ins(rs, 0, rd, 0, int'($urandom_range(8, 9)));
      default: return i_ins(8, 0, rt, 4 * int'($urandom_range(0, 60)));
    endcase
  endfunction

  initial begin
    clear_mem();
    add(0,   i_ins(8, 0, 5, 2),            5,  32'd2,        4);
    add(4,   i_ins(8, 0, 4, 0),            4,  32'd0,        8);
    add(8,   i_ins(8, 0, 9, -1),           9,  32'hffffffff, 12);
    add(12,  i_ins(1, 9, 16, 2),           31, 32'd16,       24);
    add(24,  i_ins(8, 0, 4, 4),            4,  32'd4,        28);
    add(28,  i_ins(8, 0, 9, 1),            9,  32'd1,        32);
    add(32,  i_ins(1, 9, 16, 2),           31, 32'd36,       36);
    add(36,  r_ins(4, 5, 7, 0, 37),        7,  32'd6,        40);
    add(40,  i_ins(15, 0, 8, 'h1234),      8,  32'h12340000, 44);
    add(44,  i_ins(13, 8, 8, 'h5678),      8,  32'h12345678, 48);
    add(48,  i_ins(43, 0, 8, 4),           8,  32'h12345678, 52);
    add(52,  i_ins(35, 0, 10, 4),          10, 32'h12345678, 56);
    add(56,  i_ins(8, 0, 0, 5),            0,  32'd0,        60);
    add(60,  r_ins(5, 9, 11, 0, 34),       11, 32'd1,        64);
    add(64,  r_ins(0, 0, 12, 0, 39),       12, 32'hffffffff, 68);
    add(68,  r_ins(12, 5, 13, 0, 42),      13, 32'd1,        72);
    add(72,  r_ins(12, 5, 14, 0, 43),      14, 32'd0,        76);
    add(76,  r_ins(0, 12, 15, 28, 2),      15, 32'hf,        80);
    add(80,  r_ins(0, 12, 16, 4, 3),       16, 32'hffffffff, 84);
    add(84,  r_ins(0, 5, 17, 3, 0),        17, 32'd16,       88);
    add(88,  i_ins(8, 0, 18, 0),           18, 32'd0,        92);
    add(92,  i_ins(8, 0, 19, 3),           19, 32'd3,        96);
    add(96,  i_ins(8, 18, 18, 1),          18, 32'd1,        100);
    add(100, i_ins(5, 18, 19, -2),         18, 32'd1,        96);
    add(96,  i_ins(8, 18, 18, 1),          18, 32'd2,        100);
    add(100, i_ins(5, 18, 19, -2),         18, 32'd2,        96);
    add(96,  i_ins(8, 18, 18, 1),          18, 32'd3,        100);
    add(100, i_ins(5, 18, 19, -2),         18, 32'd3,        104);
    add(104, j_ins(3, 50),                 31, 32'd108,      200);
    add(200, r_ins(31, 0, 0, 0, 8),        31, 32'd108,      108);
    add(108, i_ins(4, 0, 0, 1),            0,  32'd0,        116);
    add(116, j_ins(2, 32),                 0,  32'd0,        128);
    add(128, i_ins(8, 0, 21, 140),         21, 32'd140,      132);
    add(132, r_ins(21, 0, 20, 0, 9),       20, 32'd136,      140);
    add(140, i_ins(6, 9, 0, 2),            9,  32'd1,        144);
    add(144, i_ins(7, 9, 0, 1),            9,  32'd1,        152);
    add(152, i_ins(1, 12, 0, 1),           12, 32'hffffffff, 160);
    add(160, i_ins(1, 12, 1, 1),           12, 32'hffffffff, 164);
    add(164, 32'hfc000000,                 20, 32'd136,      168);
    add(168, r_ins(5, 5, 22, 0, 63),       22, 32'd0,        172);
    add(172, i_ins(1, 0, 17, 1),           31, 32'd176,      180);
    add(180, r_ins(5, 12, 23, 0, 33),      23, 32'd1,        184);
    add(184, i_ins(10, 12, 24, 0),         24, 32'd1,        188);
    add(188, i_ins(14, 5, 25, 'hffff),     25, 32'h0000fffd, 192);
    add(192, i_ins(12, 12, 26, 'h8001),    26, 32'h00008001, 196);
    add(196, i_ins(9, 0, 27, 'h8000),      27, 32'hffff8000, 200);
    foreach (tv[i]) put(tv[i].addr, tv[i].ins);
    put(16, i_ins(8, 0, 4, 99));
    put(20, i_ins(8, 0, 5, 99));
    put(112, i_ins(8, 0, 20, 99));
    put(120, i_ins(8, 0, 4, 99));
    put(124, i_ins(8, 0, 4, 99));
    put(148, i_ins(8, 0, 4, 99));
    put(156, i_ins(8, 0, 4, 99));
    put(176, i_ins(8, 0, 4, 99));
    #2 rst_n = 1'b0;
    #1;
    check("reset_pc", pc, 32'd0);
    check_w("reset_regs", dut_regs(), 1024'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tv[i]) begin
      @(posedge clk);
      #1;
      check($sformatf("trace%0d_pc", i), pc, tv[i].npc);
      check($sformatf("trace%0d_r%0d", i, tv[i].r), dut.registers.registers[tv[i].r], tv[i].v);
    end
    check("skip_a0", dut.registers.registers[4], 32'd4);
    check("skip_a1", dut.registers.registers[5], 32'd2);
    check("dmem_word4", {dut.dmem.bytes[4], dut.dmem.bytes[5], dut.dmem.bytes[6], dut.dmem.bytes[7]}, 32'h12345678);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, 32'd0);
    check_w("midrst_regs", dut_regs(), 1024'd0);
    check("midrst_dmem_b4", {24'd0, dut.dmem.bytes[4]}, 32'h12);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_pc", pc, 32'd4);
    check("restart_a1", dut.registers.registers[5], 32'd2);
    check("restart_a0", dut.registers.registers[4], 32'd0);
    for (int run = 0; run < 16; run++) begin
      clear_mem();
      for (int i = 0; i < 200; i++) put(4 * i, rand_ins());
      do_reset();
      for (int st = 0; st < 250 && m_pc <= 32'(MB - 4) && m_pc[1:0] == 2'b00; st++) begin
        @(posedge clk);
        m_step();
        #1;
        check($sformatf("rnd%0d_%0d_pc", run, st), pc, m_pc);
        check_w($sformatf("rnd%0d_%0d_regs", run, st), dut_regs(), model_regs());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
